// File: rtl/lockstep_pkg.sv
// Shared state encoding and update-mode constants for the lockstep pair array.
package lockstep_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_TOGGLE = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LOAD   = 2'b10;

    typedef enum logic [1:0] {
        LOCKED = 2'b00,
        FAULT  = 2'b01,
        RESYNC = 2'b10
    } state_e;

endpackage

// File: rtl/lockstep_pair.sv
// One cross-coupled x/y register pair with its equality monitor FSM.
// evt_c_o flags a mismatch event that the array counts on this edge.
module lockstep_pair
    import lockstep_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              en_i,
    input  logic [WIDTH-1:0]  load_data_i,
    input  logic              inj_i,
    input  logic [WIDTH-1:0]  inj_mask_i,
    output logic [WIDTH-1:0]  x_o,
    output logic [WIDTH-1:0]  y_o,
    output logic              locked_o,
    output logic              fault_o,
    output logic              evt_c_o
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    state_e           state_q, state_d;
    logic             mism_c;
    logic             load_c;

    assign mism_c = (x_q != y_q);
    assign load_c = en_i && (mode_i == MODE_LOAD);

    // Next-value mux; injection corrupts only x so the pair diverges.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en_i) begin
            unique case (mode_i)
                MODE_TOGGLE: begin
                    x_d = ~y_q;
                    y_d = ~x_q;
                end
                MODE_LOAD: begin
                    x_d = load_data_i;
                    y_d = load_data_i;
                end
                default: ;
            endcase
        end
        if (inj_i) begin
            x_d = x_d ^ inj_mask_i;
        end
    end

    always_comb begin
        state_d = state_q;
        evt_c_o = 1'b0;
        unique case (state_q)
            LOCKED: begin
                if (mism_c) begin
                    state_d = FAULT;
                    evt_c_o = 1'b1;
                end
            end
            FAULT: begin
                if (load_c) begin
                    state_d = RESYNC;
                end
            end
            RESYNC: begin
                if (mism_c) begin
                    state_d = FAULT;
                    evt_c_o = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            state_q <= LOCKED;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            state_q <= state_d;
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign locked_o = (state_q == LOCKED);
    assign fault_o  = (state_q == FAULT);

endmodule

// File: rtl/lockstep_pair_array.sv
// Array of lockstep x/y pairs with a shared saturating mismatch-event counter.
module lockstep_pair_array
    import lockstep_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MODE_W-1:0]         mode,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [WIDTH-1:0]          load_data,
    input  logic                      inj_en,
    input  logic [CH_W-1:0]           inj_ch,
    input  logic [WIDTH-1:0]          inj_mask,
    output logic [CHANNELS*WIDTH-1:0] x_q,
    output logic [CHANNELS*WIDTH-1:0] y_q,
    output logic [CHANNELS-1:0]       locked,
    output logic [CHANNELS-1:0]       fault,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int unsigned SUM_W = CNT_W + $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] evt_c;
    logic [SUM_W-1:0]    evt_sum_c;
    logic [SUM_W-1:0]    cnt_sum_c;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pair
        lockstep_pair #(
            .WIDTH (WIDTH)
        ) u_pair (
            .clk         (clk),
            .rst         (rst),
            .mode_i      (mode),
            .en_i        (ch_en[c]),
            .load_data_i (load_data),
            .inj_i       (inj_en && (inj_ch == CH_W'(c))),
            .inj_mask_i  (inj_mask),
            .x_o         (x_q[c*WIDTH +: WIDTH]),
            .y_o         (y_q[c*WIDTH +: WIDTH]),
            .locked_o    (locked[c]),
            .fault_o     (fault[c]),
            .evt_c_o     (evt_c[c])
        );
    end

    // Several channels may fault on one edge; add them all, then clamp.
    always_comb begin
        evt_sum_c = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            evt_sum_c = evt_sum_c + SUM_W'(evt_c[c]);
        end
        cnt_sum_c = SUM_W'(err_cnt_q) + evt_sum_c;
        err_cnt_d = (cnt_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

`ifdef FORMAL
    logic                f_past_valid_q = 1'b0;
    logic                f_inj_q;
    logic                f_rst_q;
    logic [CNT_W-1:0]    f_cnt_q;
    logic [CHANNELS-1:0] f_fault_q;

    always @(*) begin
        if (!f_past_valid_q) begin
            assume (rst);
        end
    end

    always_ff @(posedge clk) begin
        f_past_valid_q <= 1'b1;
        f_inj_q        <= inj_en;
        f_rst_q        <= rst;
        f_cnt_q        <= err_cnt;
        f_fault_q      <= fault;
    end

    // A just-injected pair is still LOCKED for the one cycle before detection.
    always @(*) begin
        if (f_past_valid_q && !f_inj_q) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                assert (!locked[c] || (x_q[c*WIDTH +: WIDTH] == y_q[c*WIDTH +: WIDTH]));
            end
        end
        if (f_past_valid_q && !f_rst_q) begin
            assert (err_cnt >= f_cnt_q);
        end
    end

`ifdef FORMAL_NO_INJ
    always @(*) begin
        assume (!inj_en);
        if (f_past_valid_q) begin
            assert ((fault & ~f_fault_q) == '0);
        end
    end
`endif
`endif

endmodule

// File: doc/lockstep_pair_array.md
# lockstep_pair_array

Parametrised array of cross-coupled register pairs (x, y) kept in lockstep. In toggle mode each pair updates x <= ~y, y <= ~x, so equality is an invariant once established. A per-channel monitor FSM detects loss of equality, latches a sticky fault, and recovers on a load; a shared saturating counter totals mismatch events. It generalises the single-bit, single-pair x/y lockstep check to WIDTH bits, CHANNELS pairs, selectable update mode, fault injection, and embedded formal properties.

## Interface
- WIDTH, 4: bits per x/y register (>=1)
- CHANNELS, 2: number of independent pairs (>=1)
- CNT_W, 8: width of mismatch event counter (>=2)
- clk  in  1  sole clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- mode  in  2  00 hold, 01 toggle, 10 load, 11 hold
- ch_en  in  CHANNELS  per-channel update enable; mode applies only where set
- load_data  in  WIDTH  value written to both x and y of enabled channels in load mode
- inj_en  in  1  fault-injection strobe
- inj_ch  in  $clog2(CHANNELS) (min 1)  channel targeted by injection
- inj_mask  in  WIDTH  XORed into next x of inj_ch
- x_q  out  CHANNELS*WIDTH  x registers, channel c at [c*WIDTH +: WIDTH]
- y_q  out  CHANNELS*WIDTH  y registers, same packing
- locked  out  CHANNELS  1 when channel FSM is LOCKED
- fault  out  CHANNELS  sticky fault, 1 in FAULT state
- err_cnt  out  CNT_W  saturating total of mismatch events

## Operation
- Next x/y per channel (ch_en[c]=1): hold keeps; toggle x<=~y, y<=~x; load x<=y<=load_data. ch_en[c]=0: hold.
- Injection: if inj_en and inj_ch==c, next x = (mode result) ^ inj_mask. inj_ch >= CHANNELS: ignored. inj_mask=0: no effect.
- A mismatch persists under toggle and hold (x^y preserved); only load clears it.
- FSM per channel, states LOCKED, FAULT, RESYNC:
  - LOCKED: x_q!=y_q at edge -> FAULT, event. Load while LOCKED -> stays LOCKED.
  - FAULT: load with ch_en[c] -> RESYNC; otherwise stay.
  - RESYNC: x_q==y_q at edge -> LOCKED; else -> FAULT, event.
- locked = (state==LOCKED); fault = (state==FAULT). RESYNC drives both 0.
- err_cnt += number of channels with an event this edge; saturates at 2^CNT_W-1, never wraps.
- Reset: x_q=y_q=0, all channels LOCKED, locked=all 1s, fault=0, err_cnt=0. Reset overrides mode, load, injection; reset mid-operation discards all state in one cycle.
- Formal (under FORMAL define): rst constrained high in the $initstate cycle; per channel assert LOCKED implies x_q==y_q; assert err_cnt non-decreasing except on reset; with inj_en constrained 0, assert fault never rises.

## Timing
- All outputs registered; no combinational input-to-output path.
- Injection sampled at edge N -> x_q differs at N; FSM -> FAULT, fault=1 and err_cnt incremented at edge N+1.
- Load in FAULT at edge N -> RESYNC at N; LOCKED at N+1 (locked high one cycle after load).
- Load plus injection on same channel same edge: values mismatched -> RESYNC then FAULT, counted as second event.
- Two channels entering FAULT on the same edge: err_cnt +2 in one cycle.

## Structure
- Package lockstep_pkg: state enum (LOCKED, FAULT, RESYNC), mode constants (MODE_HOLD, MODE_TOGGLE, MODE_LOAD).
- Sub-module lockstep_pair: one x/y pair, next-value mux, injection XOR, FSM, event output; instantiated CHANNELS times by generate.
- Top: generate loop, event popcount, saturating counter, formal properties.

## Test plan
- WIDTH=4, CHANNELS=2: rst, mode=01, ch_en=11 for 6 cycles -> x_q==y_q alternating 0x0/0xF, locked=11, err_cnt=0.
- inj_en, inj_ch=1, inj_mask=0x1 for one cycle -> one edge later fault=10, locked=01, err_cnt=1; toggle 4 more cycles -> unchanged.
- Then mode=10, load_data=0xA, ch_en=10 -> RESYNC (locked=01, fault=00) one cycle, then locked=11, x_q=y_q=0xA on channel 1.
- Inject both channels on consecutive cycles with CNT_W=2, repeated until 4 events -> err_cnt stops at 3.
- Load 0x5 with simultaneous inj_mask=0x8 on channel 0 -> RESYNC then FAULT, err_cnt +1 per event.
- rst asserted while channel 0 in FAULT -> next cycle x_q=y_q=0, locked=11, fault=00, err_cnt=0.
